// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and frame constants for the UART receiver
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_state_t;

    localparam int UART_CLKS_PER_BIT_DEF = 104;
    localparam int UART_DATA_BITS        = 8;

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for an asynchronous pin, reset to RST_VAL
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the pin through two flops to settle metastability
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with valid/ready byte output; UART_RX_PARITY_EN adds an even-parity bit and parity_err
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       overrun
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
    localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
    localparam uart_state_t AFTER_DATA = PARITY;
`else
    localparam uart_state_t AFTER_DATA = STOP;
`endif

    uart_state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [2:0] bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic rxd_s;
    logic bit_done, stop_at, stop_ok, deliver;

    sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rxd),
        .q     (rxd_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state decode and stop-sample qualifiers
    always_comb begin
        state_n  = state;
        bit_done = (cnt == LAST);
        stop_at  = (state == STOP) && bit_done;
        stop_ok  = stop_at && rxd_s;
        deliver  = stop_ok && (!rx_valid || rx_ready);
        case (state)
            IDLE:    state_n = rxd_s ? IDLE : START;
            START:   if (cnt == HALF_M1) state_n = rxd_s ? IDLE : DATA;
            DATA:    if (bit_done && bit_idx == LAST_BIT) state_n = AFTER_DATA;
            PARITY:  if (bit_done) state_n = STOP;
            STOP:    if (bit_done) state_n = rxd_s ? IDLE : BREAK;
            BREAK:   if (rxd_s) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Bit timing, shift register, holding register and status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            cnt       <= (state_n != state || state == IDLE || state == BREAK ||
                          (state == DATA && bit_done)) ? '0 : cnt + 1'b1;
            bit_idx   <= (state != DATA) ? '0 : bit_idx + 3'(bit_done);
            if (state == DATA && bit_done) shreg <= {rxd_s, shreg[UART_DATA_BITS-1:1]};
            frame_err <= stop_at && !rxd_s;
            overrun   <= stop_ok && !deliver;
            if (deliver) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;

    // Capture the parity bit and compare against even parity of the byte at stop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (state == PARITY && bit_done) par_bit <= rxd_s;
            parity_err <= stop_at && (par_bit != ^shreg);
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed self-checking bench for uart_rx against a frame-level model
module tb_uart_rx;

    localparam int CPB  = 104;
    localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 10;
`else
    localparam int NBITS = 9;
`endif
    // Pin fall driven after edge c gives E0 = c+3; stop sample = E0+HALF+NBITS*CPB
    localparam int STOP_OFF = 3 + HALF + NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fe_cnt = 0, ov_cnt = 0, vcnt = 0;
    logic [7:0] got_d[$];
    int         got_c[$];
    logic [7:0] exp_d[$];
    int         exp_c[$];
    int gi = 0;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe handshakes and status pulses mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid && rx_ready) begin
                got_d.push_back(rx_data);
                got_c.push_back(cyc);
            end
            vcnt   <= vcnt + int'(rx_valid);
            fe_cnt <= fe_cnt + int'(frame_err);
            ov_cnt <= ov_cnt + int'(overrun);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_len);
        rxd = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (CPB) tick();
        end
`ifdef UART_RX_PARITY_EN
        rxd = ^d;
        repeat (CPB) tick();
`endif
        rxd = stop;
        repeat (stop_len) tick();
    endtask

    task automatic check_rx(input string tag);
        int n;
        n = got_d.size() - gi;
        check({tag, " count"}, n, exp_d.size());
        for (int i = 0; i < exp_d.size(); i++) begin
            if (i < n) begin
                check({tag, " data"}, got_d[gi+i], exp_d[i]);
                check({tag, " cycle"}, got_c[gi+i], exp_c[i]);
            end
        end
        gi = got_d.size();
        exp_d.delete();
        exp_c.delete();
    endtask

    initial begin
        int f, c, fe0, ov0, v0, fe_exp, gap, sl;
        logic [7:0] d;
        logic bad;

        repeat (5) tick();
        check("reset rx_valid", rx_valid, 0);
        check("reset rx_data", rx_data, 0);
        check("reset frame_err", frame_err, 0);
        check("reset overrun", overrun, 0);
        rst_n = 1'b1;
        repeat (10) tick();

        fe0 = fe_cnt; ov0 = ov_cnt; v0 = vcnt;
        f = cyc;
        send_frame(8'h41, 1'b1, CPB);
        repeat (10) tick();
        exp_d.push_back(8'h41); exp_c.push_back(f + STOP_OFF);
        check_rx("byte41");
        check("byte41 valid width", vcnt - v0, 1);
        check("byte41 flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

        fe0 = fe_cnt; ov0 = ov_cnt;
        rxd = 1'b0;
        repeat (30) tick();
        rxd = 1'b1;
        repeat (1200) tick();
        check_rx("glitch");
        check("glitch flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

        fe0 = fe_cnt;
        send_frame(8'h55, 1'b0, 300);
        rxd = 1'b1;
        repeat (20) tick();
        check_rx("framing");
        check("framing frame_err", fe_cnt - fe0, 1);
        f = cyc;
        send_frame(8'hA3, 1'b1, CPB);
        repeat (10) tick();
        exp_d.push_back(8'hA3); exp_c.push_back(f + STOP_OFF);
        check_rx("after break");

        ov0 = ov_cnt;
        rx_ready = 1'b0;
        send_frame(8'h12, 1'b1, CPB);
        send_frame(8'h34, 1'b1, CPB);
        rxd = 1'b1;
        repeat (5) tick();
        check("overrun pulse", ov_cnt - ov0, 1);
        check("overrun rx_data", rx_data, 8'h12);
        check("overrun rx_valid", rx_valid, 1);
        c = cyc;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check("overrun drained", rx_valid, 0);
        exp_d.push_back(8'h12); exp_c.push_back(c);
        check_rx("overrun");

        ov0 = ov_cnt;
        send_frame(8'h12, 1'b1, CPB);
        f = cyc;
        fork
            send_frame(8'h34, 1'b1, CPB);
            begin
                repeat (STOP_OFF - 1) tick();
                rx_ready = 1'b1;
                tick();
                rx_ready = 1'b0;
            end
        join
        rxd = 1'b1;
        repeat (5) tick();
        check("same-edge overrun", ov_cnt - ov0, 0);
        check("same-edge rx_data", rx_data, 8'h34);
        check("same-edge rx_valid", rx_valid, 1);
        exp_d.push_back(8'h12); exp_c.push_back(f + STOP_OFF - 1);
        c = cyc;
        rx_ready = 1'b1;
        tick();
        exp_d.push_back(8'h34); exp_c.push_back(c);
        check_rx("same-edge");

        fe0 = fe_cnt; ov0 = ov_cnt;
        fork
            send_frame(8'hF5, 1'b1, CPB);
            begin
                repeat (5 * CPB + 20) tick();
                rst_n = 1'b0;
                repeat (20) tick();
                rst_n = 1'b1;
            end
        join
        rxd = 1'b1;
        repeat (50) tick();
        check_rx("abort");
        check("abort flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
        check("abort rx_valid", rx_valid, 0);
        f = cyc;
        send_frame(8'hF0, 1'b1, CPB);
        repeat (10) tick();
        exp_d.push_back(8'hF0); exp_c.push_back(f + STOP_OFF);
        check_rx("after reset");

        fe0 = fe_cnt; ov0 = ov_cnt; fe_exp = 0;
        for (int n = 0; n < 10; n++) begin
            d   = 8'($urandom);
            bad = ($urandom_range(0, 4) == 0);
            sl  = bad ? CPB : int'($urandom_range(HALF + 1, CPB + 10));
            f   = cyc;
            send_frame(d, !bad, sl);
            if (bad) fe_exp++;
            else begin
                exp_d.push_back(d);
                exp_c.push_back(f + STOP_OFF);
            end
            gap = int'($urandom_range(bad ? 5 : 0, 30));
            if (gap > 0) begin
                rxd = 1'b1;
                repeat (gap) tick();
            end
        end
        rxd = 1'b1;
        repeat (CPB) tick();
        check_rx("random");
        check("random frame_err", fe_cnt - fe0, fe_exp);
        check("random overrun", ov_cnt - ov0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
